pixel_readout: RTL
==================

# pixel_readout

Downstream readout stage for the pixel state machine. It captures the four 8-bit pixel values that the state machine presents after each `read1`/`read2` phase and assembles them into one frame record, tagged with an 8-bit frame number. Frames are buffered in a small FIFO and streamed out as bytes (header, then four pixels) over a valid/ready handshake. The block counts dropped frames and flags out-of-order read sequences.

## Interface
- `FIFO_DEPTH`, default 4: number of frame records buffered (power of 2, ≥2).
- `clk`  input  1  system clock; all logic on posedge.
- `reset`  input  1  asynchronous, active-low reset.
- `read1`  input  1  read phase 1 strobe from the pixel state machine.
- `read2`  input  1  read phase 2 strobe from the pixel state machine.
- `pixelDataIn1..4`  input  8 each  registered pixel values from the pixel state machine.
- `out_data`  output  8  stream byte.
- `out_valid`  output  1  `out_data` is valid.
- `out_ready`  input  1  consumer accepts the byte when high together with `out_valid`.
- `out_first`  output  1  current byte is the header.
- `out_last`  output  1  current byte is pixel 4.
- `frame_count`  output  8  frames completed since reset, including dropped frames; wraps.
- `drop_count`  output  8  frames dropped because the FIFO was full; saturates at 255.
- `overflow`  output  1  sticky; set on the first drop.
- `seq_error`  output  1  sticky; set when `read2` ends without a preceding `read1` end.
- `fifo_level`  output  $clog2(FIFO_DEPTH)+1  entries currently stored.

## Operation
- Edge detect: `read1_d`/`read2_d` are registered. A fall on `read1` (`fall1`) is `read1_d & ~read1`; `fall2` is defined the same way for `read2`.
- On `fall1`: capture `pixelDataIn1`/`pixelDataIn2` into `pix1`/`pix2` and set `half_valid`.
- On `fall2` with `half_valid` set:
  - Capture `pixelDataIn3`/`pixelDataIn4`.
  - Form the record {`frame_count`, `pix1`, `pix2`, `pix3`, `pix4`} and push it.
  - Increment `frame_count` and clear `half_valid`.
- On `fall2` with `half_valid` clear: set `seq_error`, push nothing, leave `frame_count` unchanged.
- Push when full:
  - If no pop occurs in the same cycle, the record is dropped: `drop_count`++ (saturating), `overflow` is set, and `frame_count` still increments.
  - If a pop occurs in the same cycle, the push is accepted and `fifo_level` is unchanged.
- Output FSM states:
  - `IDLE`: moves to `HDR` when the FIFO is non-empty.
  - `HDR`: drives the header byte with `out_first`=1.
  - `PIX`: uses a 2-bit index covering pixels 1..4; `out_last`=1 on index 3.
- FSM transitions:
  - Each byte advances only on `out_valid & out_ready`.
  - Acceptance of the byte with `out_last` set pops the FIFO. The FSM then goes to `HDR` if another entry remains, otherwise to `IDLE`. Frames stream back-to-back with no bubble.
- `out_data`, `out_first`, and `out_last` are held stable while `out_valid & ~out_ready`. `out_valid` never drops without acceptance.
- Simultaneous `fall1` and `fall2` in one cycle: process `fall1` first, then `fall2` with `half_valid` treated as set. This produces a complete frame using the newly captured `pix1`/`pix2`.

## Timing
- Reset (asserted low, asynchronous):
  - All outputs go to 0.
  - FIFO is emptied, FSM goes to `IDLE`, `half_valid`=0, `read*_d`=0.
  - Sticky flags clear only on reset.
- Latency: `fall2` is detected at edge N, and the record is written at edge N.
  - The FSM leaves `IDLE` at edge N+1, so `out_valid`/`out_first` are high in the cycle following N+1.
- Throughput: with `out_ready` held high, 5 cycles per frame.
- Reset mid-stream: the partial frame is discarded and no further bytes are driven.

## Structure
- Package `pixel_readout_pkg` holds:
  - typedef `frame_rec_t`, a packed struct with fields `tag`, `p1`, `p2`, `p3`, `p4` (8 bits each);
  - enum `rd_state_t` {`IDLE`, `HDR`, `PIX`};
  - constant `BYTES_PER_FRAME`=5.
- Sub-module `frame_fifo`: a synchronous FIFO of `frame_rec_t`. It is parameterised on `FIFO_DEPTH` and exposes `push`, `pop`, `full`, `empty`, and `level`. It supports simultaneous push and pop when full.

## Test plan
- Single frame: pulse `read1` with data 0x11/0x22, then `read2` with 0x33/0x44, `out_ready`=1 → stream 0x00,0x11,0x22,0x33,0x44; `out_first` on byte 0, `out_last` on byte 4; `frame_count`=1.
- Backpressure: same frame with `out_ready` toggled 1,0,0,1,… → each byte held stable until accepted; byte sequence unchanged.
- Overflow: `out_ready`=0, send 6 frames with `FIFO_DEPTH`=4 → `fifo_level`=4, `drop_count`=2, `overflow`=1, `frame_count`=6; after releasing `out_ready`, headers 0,1,2,3 are streamed.
- Sequence error: `read2` pulse with no prior `read1` → `seq_error`=1, no push, `frame_count` unchanged.
- Full plus pop same cycle: FIFO full, and the `out_last` byte is accepted in the same cycle as `fall2` → record accepted, `drop_count` unchanged, `fifo_level` stays 4.
- Reset mid-stream: assert `reset` low during byte 2 → `out_valid`=0 and all counters 0 immediately; the next frame's header is 0x00.

Source files
------------

// File: rtl/pixel_readout_pkg.sv
// Shared types for the pixel readout path: frame record layout and output FSM states.
package pixel_readout_pkg;

   typedef struct packed {
      logic [7:0] tag;
      logic [7:0] p1;
      logic [7:0] p2;
      logic [7:0] p3;
      logic [7:0] p4;
   } frame_rec_t;

   typedef enum logic [1:0] {IDLE, HDR, PIX} rd_state_t;

   localparam int BYTES_PER_FRAME = 5;

endpackage

// File: rtl/pixel_readout_frame_fifo.sv
// Synchronous FIFO of frame records, zero-cycle read of the head entry.
// A push into a full FIFO is taken only when a pop frees the slot on the same edge.
module frame_fifo
   import pixel_readout_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  frame_rec_t                    pushRec,
   input  logic                          pop,
   output frame_rec_t                    headRec,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level
);
   localparam int AW = $clog2(FIFO_DEPTH);

   frame_rec_t    mem [FIFO_DEPTH];
   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic          doPush;
   logic          doPop;

   assign full    = (level == (AW+1)'(FIFO_DEPTH));
   assign empty   = (level == '0);
   assign doPop   = pop & ~empty;
   assign doPush  = push & (~full | doPop);
   assign headRec = mem[rdPtr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         level <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + AW'(1);
         if (doPop)  rdPtr <= rdPtr + AW'(1);
         if (doPush & ~doPop)      level <= level + (AW+1)'(1);
         else if (doPop & ~doPush) level <= level - (AW+1)'(1);
      end
   end

   // Storage needs no reset: pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushRec;
   end

endmodule

// File: rtl/pixel_readout.sv
// Pairs read1/read2 captures into tagged frame records, queues them and streams header+4 pixel bytes.
// Record is written on the read2 falling-edge clock; bytes advance only on valid&ready and hold otherwise.
module pixel_readout
   import pixel_readout_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          read1,
   input  logic                          read2,
   input  logic [7:0]                    pixelDataIn1,
   input  logic [7:0]                    pixelDataIn2,
   input  logic [7:0]                    pixelDataIn3,
   input  logic [7:0]                    pixelDataIn4,
   output logic [7:0]                    out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_first,
   output logic                          out_last,
   output logic [7:0]                    frame_count,
   output logic [7:0]                    drop_count,
   output logic                          overflow,
   output logic                          seq_error,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic       read1D, read2D, fall1, fall2;
   logic       halfValid, recPush;
   logic [7:0] pix1, pix2;
   frame_rec_t pushRec, headRec;
   logic       fifoFull, fifoEmpty, fifoPop, moreQueued;
   rd_state_t  state, nextState;
   logic [1:0] pixIdx, nextPixIdx;

   assign fall1   = read1D & ~read1;
   assign fall2   = read2D & ~read2;
   // A same-cycle fall1 completes the first half before fall2 is judged.
   assign recPush = fall2 & (halfValid | fall1);

   always_comb begin
      pushRec.tag = frame_count;
      pushRec.p1  = fall1 ? pixelDataIn1 : pix1;
      pushRec.p2  = fall1 ? pixelDataIn2 : pix2;
      pushRec.p3  = pixelDataIn3;
      pushRec.p4  = pixelDataIn4;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         read1D      <= 1'b0;
         read2D      <= 1'b0;
         pix1        <= '0;
         pix2        <= '0;
         halfValid   <= 1'b0;
         frame_count <= '0;
         drop_count  <= '0;
         overflow    <= 1'b0;
         seq_error   <= 1'b0;
      end else begin
         read1D <= read1;
         read2D <= read2;
         if (fall1) begin
            pix1 <= pixelDataIn1;
            pix2 <= pixelDataIn2;
         end
         if (recPush) begin
            halfValid   <= 1'b0;
            frame_count <= frame_count + 8'd1;
            if (fifoFull & ~fifoPop) begin
               if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
               overflow <= 1'b1;
            end
         end else if (fall1) begin
            halfValid <= 1'b1;
         end
         if (fall2 & ~(halfValid | fall1)) seq_error <= 1'b1;
      end
   end

   frame_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (recPush),
      .pushRec (pushRec),
      .pop     (fifoPop),
      .headRec (headRec),
      .full    (fifoFull),
      .empty   (fifoEmpty),
      .level   (fifo_level)
   );

   // Count the record arriving this edge so frames chain with no idle bubble.
   assign moreQueued = (fifo_level > LW'(1)) | recPush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         pixIdx <= '0;
      end else begin
         state  <= nextState;
         pixIdx <= nextPixIdx;
      end
   end

   always_comb begin
      nextState  = state;
      nextPixIdx = pixIdx;
      out_valid  = 1'b0;
      out_first  = 1'b0;
      out_last   = 1'b0;
      out_data   = '0;
      fifoPop    = 1'b0;
      case (state)
         IDLE: begin
            if (!fifoEmpty) nextState = HDR;
         end
         HDR: begin
            out_valid = 1'b1;
            out_first = 1'b1;
            out_data  = headRec.tag;
            if (out_ready) begin
               nextState  = PIX;
               nextPixIdx = '0;
            end
         end
         PIX: begin
            out_valid = 1'b1;
            out_last  = (pixIdx == 2'(BYTES_PER_FRAME - 2));
            case (pixIdx)
               2'd0:    out_data = headRec.p1;
               2'd1:    out_data = headRec.p2;
               2'd2:    out_data = headRec.p3;
               default: out_data = headRec.p4;
            endcase
            if (out_ready) begin
               if (out_last) begin
                  fifoPop   = 1'b1;
                  nextState = moreQueued ? HDR : IDLE;
               end else begin
                  nextPixIdx = pixIdx + 2'd1;
               end
            end
         end
         default: nextState = IDLE;
      endcase
   end

endmodule
